// File: rtl/arb_pkg.sv
// Shared types for the two-port memory arbiter: ownership state and port indices.
package arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_t;

  localparam logic ARB_P0 = 1'b0;
  localparam logic ARB_P1 = 1'b1;

  // Ownership state that follows a grant to port p with lock request lk.
  function automatic owner_t owner_after(input logic p, input logic lk);
    if (!lk) return OWN_IDLE;
    return (p == ARB_P1) ? OWN_1 : OWN_0;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational grant pick: honours a live locked owner until its burst limit,
// otherwise round-robin against the last granted port. Zero latency.
module arb_rr_pick
  import arb_pkg::*;
(
  input  logic   req0,
  input  logic   req1,
  input  owner_t owner,
  input  logic   last,
  input  logic   at_limit,
  output logic   gnt0,
  output logic   gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (owner == OWN_0 && req0) begin
      // Owner keeps the memory unless it has used up its burst and port 1 waits.
      if (at_limit && req1) gnt1 = 1'b1;
      else                  gnt0 = 1'b1;
    end else if (owner == OWN_1 && req1) begin
      if (at_limit && req0) gnt0 = 1'b1;
      else                  gnt1 = 1'b1;
    end else if (req0 && req1) begin
      if (last == ARB_P0) gnt1 = 1'b1;
      else                gnt0 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between the core (port 0) and a loader/DMA (port 1); grant and
// access happen in the request cycle, losers simply see no gnt and hold their request.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAXBURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] adr0,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int            BW   = $clog2(MAXBURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAXBURST);

  owner_t        owner, owner_nxt;
  logic          last, last_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic          at_limit;
  logic          pick0, pick1;

  assign at_limit = (bcnt == BMAX);

  arb_rr_pick u_pick (
    .req0     (req0),
    .req1     (req1),
    .owner    (owner),
    .last     (last),
    .at_limit (at_limit),
    .gnt0     (pick0),
    .gnt1     (pick1)
  );

  // Reset gates the grants combinationally so a write in flight is dropped at once.
  assign gnt0 = pick0 & ~reset;
  assign gnt1 = pick1 & ~reset;

  always_comb begin
    mem_we  = 1'b0;
    mem_adr = adr0;
    mem_wd  = wd0;
    if (gnt1) begin
      mem_we  = we1;
      mem_adr = adr1;
      mem_wd  = wd1;
    end else if (gnt0) begin
      mem_we  = we0;
    end
  end

  assign rd = mem_rd;

  // The burst counter only runs while the same locked owner keeps winning over a waiting peer.
  always_comb begin
    owner_nxt = OWN_IDLE;
    last_nxt  = last;
    bcnt_nxt  = '0;
    if (gnt0) begin
      last_nxt  = ARB_P0;
      owner_nxt = owner_after(ARB_P0, lock0);
      if (owner == OWN_0 && lock0 && req1)
        bcnt_nxt = at_limit ? bcnt : bcnt + BW'(1);
    end else if (gnt1) begin
      last_nxt  = ARB_P1;
      owner_nxt = owner_after(ARB_P1, lock1);
      if (owner == OWN_1 && lock1 && req0)
        bcnt_nxt = at_limit ? bcnt : bcnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= OWN_IDLE;
      last  <= ARB_P1;
      bcnt  <= '0;
    end else begin
      owner <= owner_nxt;
      last  <= last_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  a_onehot_gnt : assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));
  a_bcnt_range : assert property (@(posedge clk) disable iff (reset) bcnt <= BMAX);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// two-master traffic checked every cycle against a rule-level arbitration model.
module tb_mem_arbiter;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAXBURST = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, lock0, lock1, we0, we1;
  logic [AW-1:0] adr0, adr1;
  logic [DW-1:0] wd0, wd1;
  logic          gnt0, gnt1, mem_we;
  logic [DW-1:0] rd, mem_wd, mem_rd;
  logic [AW-1:0] mem_adr;

  logic [DW-1:0] mem_arr [64];
  logic [DW-1:0] ref_mem [64];

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b1;

  // Model state: owner -1 = nobody, streak = consecutive locked re-grants against a waiting peer.
  int m_owner = -1;
  int m_last  = 1;
  int m_streak = 0;
  int e_g = -1;
  logic e_we;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_wd;
  logic m_lk, m_oth;

  mem_arbiter #(.AW(AW), .DW(DW), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .adr0(adr0), .adr1(adr1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .rd(rd),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem_arr[mem_adr[7:2]];

  always @(posedge clk) if (mem_we) mem_arr[mem_adr[7:2]] <= mem_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic r0, input logic r1);
    if (!r0 && !r1) return -1;
    if (r0 != r1) return r0 ? 0 : 1;
    if (m_owner >= 0) return (m_streak >= MAXBURST) ? 1 - m_owner : m_owner;
    return 1 - m_last;
  endfunction

  always @(negedge clk) if (chk_en) begin
    e_g   = reset ? -1 : model_pick(req0, req1);
    e_we  = (e_g == 0) ? we0 : (e_g == 1) ? we1 : 1'b0;
    e_adr = (e_g == 1) ? adr1 : adr0;
    e_wd  = (e_g == 1) ? wd1 : wd0;
    chk("gnt0", 32'(gnt0), 32'(e_g == 0));
    chk("gnt1", 32'(gnt1), 32'(e_g == 1));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_adr", mem_adr, e_adr);
    chk("mem_wd", mem_wd, e_wd);
    chk("rd_pass", rd, mem_rd);
    if (e_g >= 0 && !e_we) chk("rd_data", rd, ref_mem[e_adr[7:2]]);
  end

  always @(posedge clk) if (chk_en) begin
    if (reset) begin
      m_owner = -1; m_last = 1; m_streak = 0;
    end else if (e_g < 0) begin
      m_owner = -1; m_streak = 0;
    end else begin
      m_lk  = (e_g == 0) ? lock0 : lock1;
      m_oth = (e_g == 0) ? req1 : req0;
      if (e_we) ref_mem[e_adr[7:2]] = e_wd;
      if (m_owner == e_g && m_lk && m_oth) m_streak = (m_streak < MAXBURST) ? m_streak + 1 : m_streak;
      else m_streak = 0;
      m_owner = m_lk ? e_g : -1;
      m_last  = e_g;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic new_req(output logic r, output logic l, output logic w,
                         output logic [AW-1:0] a, output logic [DW-1:0] d);
    r = ($urandom_range(0, 3) != 0);
    l = ($urandom_range(0, 4) != 0);
    w = 1'($urandom_range(0, 1));
    a = AW'($urandom_range(0, 63)) << 2;
    d = $urandom;
  endtask

  initial begin
    logic [3:0] pat;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b1; adr0 = 32'h40; wd0 = 32'hDEADBEEF; lock0 = 1'b0;
    req1 = 1'b0; we1 = 1'b0; adr1 = '0;     wd1 = '0;           lock1 = 1'b0;

    cyc(); #4;
    chk("lit_reset_gnt0", 32'(gnt0), 32'd0);
    chk("lit_reset_we", 32'(mem_we), 32'd0);

    cyc(); reset = 1'b0; #4;
    chk("lit_wr_gnt0", 32'(gnt0), 32'd1);
    chk("lit_wr_gnt1", 32'(gnt1), 32'd0);
    chk("lit_wr_we", 32'(mem_we), 32'd1);
    chk("lit_wr_adr", mem_adr, 32'h40);

    cyc(); we0 = 1'b0; #4;
    chk("lit_rd_gnt0", 32'(gnt0), 32'd1);
    chk("lit_rd_data", rd, 32'hDEADBEEF);

    cyc(); req0 = 1'b0; adr0 = 32'h80; #4;
    chk("lit_idle_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("lit_idle_we", 32'(mem_we), 32'd0);
    chk("lit_idle_adr", mem_adr, 32'h80);

    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
    pat = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      #4;
      chk("lit_tie_gnt1", 32'(gnt1), 32'(pat[i]));
      chk("lit_tie_gnt0", 32'(gnt0), 32'(!pat[i]));
    end

    cyc(); req0 = 1'b0; req1 = 1'b1; lock1 = 1'b1; #4;
    chk("lit_burst_first", 32'(gnt1), 32'd1);
    for (int i = 0; i < MAXBURST; i++) begin
      cyc(); req0 = 1'b1; #4;
      chk("lit_burst_hold", 32'(gnt1), 32'd1);
    end
    cyc(); #4;
    chk("lit_burst_hand0", 32'(gnt0), 32'd1);
    chk("lit_burst_hand1", 32'(gnt1), 32'd0);

    cyc(); #4;
    chk("lit_rel_own1", 32'(gnt1), 32'd1);
    cyc(); req1 = 1'b0; #4;
    chk("lit_rel_gnt0", 32'(gnt0), 32'd1);
    chk("lit_rel_gnt1", 32'(gnt1), 32'd0);
    cyc(); req1 = 1'b1; lock1 = 1'b0; #4;
    chk("lit_rel_idle", 32'(gnt1), 32'd1);

    cyc(); req0 = 1'b0; lock1 = 1'b1; we1 = 1'b1; adr1 = 32'h10; wd1 = 32'h1234; #4;
    chk("lit_mid_g1", 32'(gnt1), 32'd1);
    cyc(); req0 = 1'b1; #4;
    chk("lit_mid_g1b", 32'(gnt1), 32'd1);
    #1; reset = 1'b1; #1;
    chk("lit_mid_rst_g1", 32'(gnt1), 32'd0);
    chk("lit_mid_rst_we", 32'(mem_we), 32'd0);
    cyc();
    cyc(); reset = 1'b0; lock1 = 1'b0; we1 = 1'b0; #4;
    chk("lit_mid_tie", 32'(gnt0), 32'd1);

    for (int c = 0; c < 4000; c++) begin
      cyc();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 249) == 0) reset = 1'b1;
      if (!req0 || e_g == 0) new_req(req0, lock0, we0, adr0, wd0);
      if (!req1 || e_g == 1) new_req(req1, lock1, we1, adr1, wd1);
    end

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
